// File: rtl/fp_addsub_pipe_if.sv
// Valid/ready operand and result bundle for the pipelined floating-point adder/subtractor.
interface fp_addsub_pipe_if #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
);
   localparam int unsigned W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic         op_sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;

   modport master (
      output in_valid, op_sub, a, b, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, op_sub, a, b, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined FP add/subtract: unpack/align, add/normalise, round/pack.
// Round-to-nearest-even, subnormals flushed to zero, one global advance enable.
module fp_addsub_pipe #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input logic             clk,
   input logic             rst_n,
   fp_addsub_pipe_if.slave bus
);
   localparam int unsigned W    = 1 + EXP_W + MAN_W;
   localparam int unsigned SW   = MAN_W + 4;
   localparam int unsigned LZ_W = $clog2(SW + 1);
   localparam int unsigned XE_W = EXP_W + LZ_W + 2;
   localparam logic [EXP_W-1:0] EXP_MAX = '1;
   localparam logic [W-1:0]     QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

   typedef struct packed {
      logic             valid;
      logic             special;
      logic [W-1:0]     spec_res;
      logic [3:0]       spec_flags;
      logic             sign_x;
      logic             sign_y;
      logic [EXP_W-1:0] exp_x;
      logic [SW-1:0]    sig_x;
      logic [SW-1:0]    sig_y;
   } s1_t;

   typedef struct packed {
      logic             valid;
      logic             special;
      logic [W-1:0]     spec_res;
      logic [3:0]       spec_flags;
      logic             sign;
      logic             zero;
      logic [XE_W-1:0]  expo;
      logic [SW-1:0]    sig;
   } s2_t;

   s1_t          s1_n, s1_q;
   s2_t          s2_n, s2_q;
   logic         out_valid_q;
   logic [W-1:0] result_q, res_n;
   logic [3:0]   flags_q, flags_n;
   logic         adv;

   assign adv           = !out_valid_q || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.flags     = flags_q;

   // Stage 1: classify, order by magnitude, align the smaller significand.
   logic             sign_a, sign_b, zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, swap;
   logic [EXP_W-1:0] exp_a, exp_b, exp_y, shamt;
   logic [MAN_W-1:0] frac_a, frac_b;
   logic [SW-1:0]    sig_a, sig_b, sig_yf, sig_ys;

   always_comb begin
      s1_n   = '0;
      sign_a = bus.a[W-1];
      sign_b = bus.b[W-1] ^ bus.op_sub;
      exp_a  = bus.a[W-2 -: EXP_W];
      exp_b  = bus.b[W-2 -: EXP_W];
      zero_a = (exp_a == '0);
      zero_b = (exp_b == '0);
      inf_a  = (exp_a == EXP_MAX) && (bus.a[MAN_W-1:0] == '0);
      inf_b  = (exp_b == EXP_MAX) && (bus.b[MAN_W-1:0] == '0);
      nan_a  = (exp_a == EXP_MAX) && (bus.a[MAN_W-1:0] != '0);
      nan_b  = (exp_b == EXP_MAX) && (bus.b[MAN_W-1:0] != '0);
      frac_a = zero_a ? '0 : bus.a[MAN_W-1:0];
      frac_b = zero_b ? '0 : bus.b[MAN_W-1:0];
      sig_a  = zero_a ? '0 : {1'b1, frac_a, 3'b000};
      sig_b  = zero_b ? '0 : {1'b1, frac_b, 3'b000};
      swap   = {exp_b, frac_b} > {exp_a, frac_a};

      s1_n.valid  = bus.in_valid;
      s1_n.sign_x = swap ? sign_b : sign_a;
      s1_n.sign_y = swap ? sign_a : sign_b;
      s1_n.exp_x  = swap ? exp_b : exp_a;
      s1_n.sig_x  = swap ? sig_b : sig_a;
      exp_y       = swap ? exp_a : exp_b;
      sig_yf      = swap ? sig_a : sig_b;
      shamt       = s1_n.exp_x - exp_y;

      // Bits pushed past the sticky position collapse into the sticky bit.
      if (32'(shamt) >= SW - 1) begin
         sig_ys = SW'(|sig_yf);
      end else begin
         sig_ys = sig_yf >> shamt;
         if ((sig_ys << shamt) != sig_yf) sig_ys[0] = 1'b1;
      end
      s1_n.sig_y = sig_ys;

      if (nan_a || nan_b) begin
         s1_n.special  = 1'b1;
         s1_n.spec_res = QNAN;
      end else if (inf_a && inf_b && (sign_a != sign_b)) begin
         s1_n.special    = 1'b1;
         s1_n.spec_res   = QNAN;
         s1_n.spec_flags = 4'b1000;
      end else if (inf_a) begin
         s1_n.special  = 1'b1;
         s1_n.spec_res = {sign_a, EXP_MAX, {MAN_W{1'b0}}};
      end else if (inf_b) begin
         s1_n.special  = 1'b1;
         s1_n.spec_res = {sign_b, EXP_MAX, {MAN_W{1'b0}}};
      end
   end

   // Stage 2: add or subtract magnitudes, then normalise.
   logic [SW:0]     sum;
   logic [LZ_W-1:0] lzc;
   logic            eff_sub;

   always_comb begin
      s2_n            = '0;
      s2_n.valid      = s1_q.valid;
      s2_n.special    = s1_q.special;
      s2_n.spec_res   = s1_q.spec_res;
      s2_n.spec_flags = s1_q.spec_flags;
      s2_n.sign       = s1_q.sign_x;
      eff_sub         = s1_q.sign_x ^ s1_q.sign_y;
      sum = eff_sub ? ({1'b0, s1_q.sig_x} - {1'b0, s1_q.sig_y})
                    : ({1'b0, s1_q.sig_x} + {1'b0, s1_q.sig_y});
      lzc = '0;
      for (int i = 0; i < SW; i++) begin
         if (sum[i]) lzc = LZ_W'(SW - 1 - i);
      end

      if (sum[SW]) begin
         s2_n.sig  = {sum[SW:2], sum[1] | sum[0]};
         s2_n.expo = XE_W'(s1_q.exp_x) + XE_W'(1);
      end else if (sum == '0) begin
         // Exact cancellation is +0; only like-signed zeros keep their sign.
         s2_n.zero = 1'b1;
         s2_n.sign = s1_q.sign_x & ~eff_sub;
      end else begin
         s2_n.sig  = sum[SW-1:0] << lzc;
         s2_n.expo = XE_W'(s1_q.exp_x) - XE_W'(lzc);
      end
   end

   // Stage 3: round to nearest even, range check, pack.
   logic             g, r, s, lsb, rnd, inex;
   logic [MAN_W+1:0] mant;
   logic [XE_W-1:0]  exp_r;
   logic [MAN_W-1:0] frac;

   always_comb begin
      g     = s2_q.sig[2];
      r     = s2_q.sig[1];
      s     = s2_q.sig[0];
      lsb   = s2_q.sig[3];
      rnd   = g & (r | s | lsb);
      inex  = g | r | s;
      mant  = {1'b0, s2_q.sig[SW-1:3]} + (MAN_W+2)'(rnd);
      exp_r = s2_q.expo;
      frac  = mant[MAN_W-1:0];
      if (mant[MAN_W+1]) begin
         exp_r = s2_q.expo + XE_W'(1);
         frac  = mant[MAN_W:1];
      end

      res_n   = {s2_q.sign, exp_r[EXP_W-1:0], frac};
      flags_n = {3'b000, inex};
      if (s2_q.special) begin
         res_n   = s2_q.spec_res;
         flags_n = s2_q.spec_flags;
      end else if (s2_q.zero) begin
         res_n   = {s2_q.sign, {(W-1){1'b0}}};
         flags_n = 4'b0000;
      end else if (exp_r[XE_W-1] || (exp_r == '0)) begin
         res_n   = {s2_q.sign, {(W-1){1'b0}}};
         flags_n = 4'b0011;
      end else if (exp_r >= XE_W'(EXP_MAX)) begin
         res_n   = {s2_q.sign, EXP_MAX, {MAN_W{1'b0}}};
         flags_n = 4'b0101;
      end
   end

   // Whole pipe moves together whenever the output slot is free or draining.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q        <= '0;
         s2_q        <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else if (adv) begin
         s1_q        <= s1_n;
         s2_q        <= s2_n;
         out_valid_q <= s2_q.valid;
         result_q    <= res_n;
         flags_q     <= flags_n;
      end
   end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed and reference-model checks for fp_addsub_pipe (single and half precision).
module tb_fp_addsub_pipe;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();
   fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   fp_addsub_pipe_if #(.EXP_W(5), .MAN_W(10)) bus_h ();
   fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .rst_n(rst_n), .bus(bus_h));

   // Exact-sum reference with RNE; valid when exponents stay well inside the normal range.
   function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub);
      logic        sx, sy, st, inex;
      logic [7:0]  ex, ey, et;
      logic [63:0] mx, my, mt, sum, rem, half, mant;
      int          d, p, sh, e;
      sx = a[31]; sy = b[31] ^ sub; ex = a[30:23]; ey = b[30:23];
      mx = {40'd0, 1'b1, a[22:0]};
      my = {40'd0, 1'b1, b[22:0]};
      if (b[30:0] > a[30:0]) begin
         st = sx; sx = sy; sy = st;
         et = ex; ex = ey; ey = et;
         mt = mx; mx = my; my = mt;
      end
      d   = int'(ex) - int'(ey);
      mx  = mx << d;
      sum = (sx ^ sy) ? mx - my : mx + my;
      if (sum == 64'd0) return 36'd0;
      p = 0;
      for (int i = 0; i < 64; i++) if (sum[i]) p = i;
      inex = 1'b0;
      if (p > 23) begin
         sh   = p - 23;
         rem  = sum & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         mant = sum >> sh;
         inex = (rem != 64'd0);
         if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
         if (mant[24]) begin
            mant = mant >> 1;
            p    = p + 1;
         end
      end else begin
         mant = sum << (23 - p);
      end
      e = int'(ey) + p - 23;
      return {3'b000, inex, sx, 8'(e), mant[22:0]};
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         output logic [31:0] res, output logic [3:0] fl, output int lat);
      int n;
      bus.a = a; bus.b = b; bus.op_sub = sub; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
      #1;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      if (bus.out_valid) begin
         res = bus.result; fl = bus.flags;
      end else begin
         res = 'x; fl = 'x; lat = 99;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.op_sub = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
      bus_h.in_valid = 1'b0; bus_h.op_sub = 1'b0; bus_h.a = '0; bus_h.b = '0;
      bus_h.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.flags !== 4'd0) begin
         bad++;
         $display("FAIL reset_state got v=%b r=%h f=%b want v=0 r=0 f=0",
                  bus.out_valid, bus.result, bus.flags);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus_h.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release got ready=%b v=%b vh=%b want 1 0 0",
                  bus.in_ready, bus.out_valid, bus_h.out_valid);
      end
   endtask

   task automatic test_basic_add();
      logic [31:0] r; logic [3:0] f; int lat;
      run_op(32'h3F800000, 32'h40000000, 1'b0, r, f, lat);
      total++;
      if (r !== 32'h40400000 || f !== 4'b0000) begin
         bad++;
         $display("FAIL basic_add got %h/%b want 40400000/0000", r, f);
      end
      total++;
      if (lat !== 3) begin
         bad++;
         $display("FAIL basic_latency got %0d want 3", lat);
      end
   endtask

   task automatic test_cancel_ties();
      logic [31:0] opa [3]; logic [31:0] opb [3]; logic ops [3];
      logic [31:0] want_r [3]; logic [3:0] want_f [3];
      logic [31:0] r; logic [3:0] f; int lat;
      opa    = '{32'h3F800000, 32'h3F800000, 32'h3F800001};
      opb    = '{32'h3F800000, 32'h33800000, 32'h33800000};
      ops    = '{1'b1, 1'b0, 1'b0};
      want_r = '{32'h00000000, 32'h3F800000, 32'h3F800002};
      want_f = '{4'b0000, 4'b0001, 4'b0001};
      for (int i = 0; i < 3; i++) begin
         run_op(opa[i], opb[i], ops[i], r, f, lat);
         total++;
         if (r !== want_r[i] || f !== want_f[i]) begin
            bad++;
            $display("FAIL cancel_ties[%0d] got %h/%b want %h/%b", i, r, f, want_r[i], want_f[i]);
         end
      end
   endtask

   task automatic test_overflow_specials();
      logic [31:0] opa [6]; logic [31:0] opb [6]; logic ops [6];
      logic [31:0] want_r [6]; logic [3:0] want_f [6];
      logic [31:0] r; logic [3:0] f; int lat;
      opa    = '{32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001, 32'h7F800000, 32'h3F800000, 32'h00800001};
      opb    = '{32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h00800000};
      ops    = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      want_r = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h00000000};
      want_f = '{4'b0101, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0011};
      for (int i = 0; i < 6; i++) begin
         run_op(opa[i], opb[i], ops[i], r, f, lat);
         total++;
         if (r !== want_r[i] || f !== want_f[i]) begin
            bad++;
            $display("FAIL specials[%0d] got %h/%b want %h/%b", i, r, f, want_r[i], want_f[i]);
         end
      end
   endtask

   task automatic test_zero_sign();
      logic [31:0] opa [5]; logic [31:0] opb [5]; logic ops [5];
      logic [31:0] want_r [5];
      logic [31:0] r; logic [3:0] f; int lat;
      opa    = '{32'h80000000, 32'h40400000, 32'h00000000, 32'h3F800000, 32'h00000001};
      opb    = '{32'h80000000, 32'h40400000, 32'h80000000, 32'hBF800000, 32'h3F800000};
      ops    = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      want_r = '{32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h3F800000};
      for (int i = 0; i < 5; i++) begin
         run_op(opa[i], opb[i], ops[i], r, f, lat);
         total++;
         if (r !== want_r[i] || f !== 4'b0000) begin
            bad++;
            $display("FAIL zero_sign[%0d] got %h/%b want %h/0000", i, r, f, want_r[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] opa [5]; logic [31:0] opb [5]; logic ops [5]; logic [31:0] want_r [5];
      logic [31:0] r, held; logic rdy, ov; int idx, got;
      opa    = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h3F800000};
      opb    = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h40000000};
      ops    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      want_r = '{32'h40400000, 32'h40800000, 32'h40000000, 32'h40A00000, 32'hBF800000};
      bus.out_ready = 1'b0;
      idx = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         bus.a = opa[idx]; bus.b = opb[idx]; bus.op_sub = ops[idx]; bus.in_valid = 1'b1;
         #1;
         rdy = bus.in_ready;
         @(posedge clk); #1;
         if (rdy) idx++;
      end
      total++;
      if (idx !== 3 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL stall_accepts got acc=%0d ready=%b v=%b want 3 0 1",
                  idx, bus.in_ready, bus.out_valid);
      end
      held = bus.result;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (bus.result !== want_r[0] || held !== want_r[0] || bus.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL stall_hold got %h then %h v=%b want %h", held, bus.result,
                  bus.out_valid, want_r[0]);
      end
      bus.out_ready = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
         if (idx < 5) begin
            bus.a = opa[idx]; bus.b = opb[idx]; bus.op_sub = ops[idx]; bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         rdy = bus.in_ready; ov = bus.out_valid; r = bus.result;
         @(posedge clk); #1;
         if (rdy && idx < 5) idx++;
         if (ov) begin
            total++;
            if (r !== want_r[got]) begin
               bad++;
               $display("FAIL drain[%0d] got %h want %h", got, r, want_r[got]);
            end
            got++;
         end
      end
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (got !== 5 || bus.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL drain_count got %0d v=%b want 5 v=0", got, bus.out_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r; logic [3:0] f; int lat, seen;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.a = 32'h3F800000; bus.b = 32'h40000000; bus.op_sub = 1'b0; bus.in_valid = 1'b1;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid_state got v=%b r=%h ready=%b want 0 0 1",
                  bus.out_valid, bus.result, bus.in_ready);
      end
      bus.out_ready = 1'b1;
      seen = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL reset_mid_stale got %0d results want 0", seen);
      end
      run_op(32'h3F800000, 32'h40400000, 1'b0, r, f, lat);
      total++;
      if (r !== 32'h40800000 || f !== 4'b0000 || lat !== 3) begin
         bad++;
         $display("FAIL reset_mid_new got %h/%b lat=%0d want 40800000/0000 lat=3", r, f, lat);
      end
   endtask

   task automatic test_half();
      logic [15:0] opa [3]; logic [15:0] opb [3]; logic ops [3];
      logic [15:0] want_r [3]; logic [3:0] want_f [3];
      int n;
      opa    = '{16'h3C00, 16'h3C00, 16'h7BFF};
      opb    = '{16'h3C00, 16'h3C00, 16'h7BFF};
      ops    = '{1'b0, 1'b1, 1'b0};
      want_r = '{16'h4000, 16'h0000, 16'h7C00};
      want_f = '{4'b0000, 4'b0000, 4'b0101};
      bus_h.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus_h.a = opa[i]; bus_h.b = opb[i]; bus_h.op_sub = ops[i]; bus_h.in_valid = 1'b1;
         @(posedge clk); #1;
         bus_h.in_valid = 1'b0;
         n = 0;
         while (!bus_h.out_valid && n < 20) begin
            @(posedge clk); #1; n++;
         end
         total++;
         if (bus_h.out_valid !== 1'b1 || bus_h.result !== want_r[i] || bus_h.flags !== want_f[i]) begin
            bad++;
            $display("FAIL half[%0d] got v=%b %h/%b want %h/%b", i, bus_h.out_valid,
                     bus_h.result, bus_h.flags, want_r[i], want_f[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random_stream();
      logic [35:0] exp_q [$];
      logic [35:0] w;
      logic [31:0] ra, rb, r;
      logic [7:0]  ea, eb;
      logic [3:0]  f;
      logic        rs, rdy, ov, ordy;
      int          sent, got;
      sent = 0; got = 0;
      ea = 8'($urandom_range(110, 140));
      eb = 8'(int'(ea) - 30 + int'($urandom_range(0, 60)));
      ra = {1'($urandom_range(0, 1)), ea, 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), eb, 23'($urandom)};
      rs = 1'($urandom_range(0, 1));
      for (int cyc = 0; cyc < 800 && got < 40; cyc++) begin
         bus.a = ra; bus.b = rb; bus.op_sub = rs; bus.in_valid = (sent < 40);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         #1;
         rdy = bus.in_ready && bus.in_valid; ov = bus.out_valid; ordy = bus.out_ready;
         r = bus.result; f = bus.flags;
         @(posedge clk); #1;
         if (rdy) begin
            exp_q.push_back(ref_add(ra, rb, rs));
            sent++;
            ea = 8'($urandom_range(110, 140));
            eb = 8'(int'(ea) - 30 + int'($urandom_range(0, 60)));
            ra = {1'($urandom_range(0, 1)), ea, 23'($urandom)};
            rb = {1'($urandom_range(0, 1)), eb, 23'($urandom)};
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) rb = ra ^ {~rs, 31'd0};
         end
         if (ov && ordy) begin
            w = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hx;
            total++;
            if (r !== w[31:0] || f !== w[35:32]) begin
               bad++;
               $display("FAIL random[%0d] got %h/%b want %h/%b", got, r, f, w[31:0], w[35:32]);
            end
            got++;
         end
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      total++;
      if (got !== 40) begin
         bad++;
         $display("FAIL random_count got %0d want 40", got);
      end
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_cancel_ties();
      test_overflow_specials();
      test_zero_sign();
      test_back_to_back();
      test_reset_mid();
      test_half();
      test_random_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
